// File: rtl/pid_pkg.sv
// pid_pkg -- shared definitions for the saturating PID controller.
//   state_t      : sequencing states of the controller
//   SAT_*        : bit positions inside the 3-bit saturation vector
//   DEF_*        : default widths and integrator limit
//   clamp_s      : generic signed clamp on a wide working width
package pid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        MP,
        MI,
        MD,
        SUM
    } state_t;

    localparam int SAT_ERR = 0;
    localparam int SAT_INT = 1;
    localparam int SAT_OUT = 2;

    localparam int DEF_DW = 16;
    localparam int DEF_OW = 32;

    // Working width for all intermediate sums; wide enough that nothing in
    // the datapath can wrap before it is clamped.
    localparam int CW = 128;

    // Default integrator limit 2^(ow-2)-1.
    function automatic longint def_i_max(input int ow);
        return (longint'(1) <<< (ow - 2)) - longint'(1);
    endfunction

    function automatic logic signed [CW-1:0] clamp_s(
        input logic signed [CW-1:0] x,
        input logic signed [CW-1:0] lo,
        input logic signed [CW-1:0] hi
    );
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/pid_mul.sv
// pid_mul -- purely combinational signed DW x DW -> 2*DW multiplier.
//   a, b : signed operands
//   p    : full-width signed product
module pid_mul #(
    parameter int DW = 16
) (
    input  logic signed [DW-1:0]   a,
    input  logic signed [DW-1:0]   b,
    output logic signed [2*DW-1:0] p
);

    // Both operands are sign-extended to the product width first, so the
    // low 2*DW bits of the multiply are the exact signed product.
    assign p = (2*DW)'(a) * (2*DW)'(b);

endmodule

// File: rtl/pid_sat.sv
// pid_sat -- sequential PID controller with saturation at every stage.
//   clk, rst         : clock and synchronous active-high reset
//   in_valid/in_ready: sample handshake; inputs captured on accept
//   kp, ki, kd       : signed gains
//   sv, pv           : signed set value and present value
//   int_clr          : clears the integrator at the next edge
//   out_valid        : one-cycle strobe for a new mv
//   mv               : signed manipulation value, held between strobes
//   sat              : {out_clamped, int_clamped, err_clamped}
//   sat_sticky       : OR-accumulation of sat since reset
module pid_sat
    import pid_pkg::*;
#(
    parameter int     DW    = DEF_DW,
    parameter int     OW    = DEF_OW,
    parameter longint I_MAX = def_i_max(OW)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] kp,
    input  logic signed [DW-1:0] ki,
    input  logic signed [DW-1:0] kd,
    input  logic signed [DW-1:0] sv,
    input  logic signed [DW-1:0] pv,
    input  logic                 int_clr,
    output logic                 out_valid,
    output logic signed [OW-1:0] mv,
    output logic [2:0]           sat,
    output logic [2:0]           sat_sticky
);

    localparam logic signed [CW-1:0] ONE    = CW'(1);
    localparam logic signed [CW-1:0] DW_MAX = (ONE <<< (DW - 1)) - ONE;
    localparam logic signed [CW-1:0] DW_MIN = -(ONE <<< (DW - 1));
    localparam logic signed [CW-1:0] OW_MAX = (ONE <<< (OW - 1)) - ONE;
    localparam logic signed [CW-1:0] OW_MIN = -(ONE <<< (OW - 1));
    localparam logic signed [CW-1:0] IM_HI  = CW'(I_MAX);
    localparam logic signed [CW-1:0] IM_LO  = -IM_HI;

    state_t state, state_next;
    logic   accept;

    logic signed [DW-1:0]   kp_r, ki_r, kd_r, sv_r, pv_r;
    logic signed [DW-1:0]   e_r, de_r, e_prev;
    logic signed [2*DW-1:0] p_term, d_term;
    logic signed [OW-1:0]   i_acc;
    logic                   err_flag, int_flag;

    logic signed [DW-1:0]   mul_a, mul_b;
    logic signed [2*DW-1:0] prod;

    logic signed [CW-1:0]   diff_w, e_w, dd_w, de_w;
    logic signed [CW-1:0]   isum_w, iclamp_w, ssum_w, oclamp_w;
    logic signed [DW-1:0]   e_c, de_c;
    logic signed [OW-1:0]   i_next, mv_next;
    logic                   err_c, int_c, out_c;

    // State register; reset always lands in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a fixed one-cycle-per-step walk, left only on accept.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ERR;
            ERR:     state_next = MP;
            MP:      state_next = MI;
            MI:      state_next = MD;
            MD:      state_next = SUM;
            SUM:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: the block is only ready while idle.
    always_comb begin
        in_ready = (state == IDLE);
        accept   = in_valid && in_ready;
    end

    // Operand select for the single shared multiplier.
    always_comb begin
        mul_a = kp_r;
        mul_b = e_r;
        case (state)
            MI: begin
                mul_a = ki_r;
                mul_b = e_r;
            end
            MD: begin
                mul_a = kd_r;
                mul_b = de_r;
            end
            default: begin
                mul_a = kp_r;
                mul_b = e_r;
            end
        endcase
    end

    pid_mul #(.DW(DW)) u_mul (
        .a(mul_a),
        .b(mul_b),
        .p(prod)
    );

    // Saturating arithmetic: every result is formed wide, clamped, and the
    // clamp flag is simply "the clamped value differs from the raw one".
    always_comb begin
        diff_w   = CW'(sv_r) - CW'(pv_r);
        e_w      = clamp_s(diff_w, DW_MIN, DW_MAX);
        e_c      = e_w[DW-1:0];
        dd_w     = CW'(e_c) - CW'(e_prev);
        de_w     = clamp_s(dd_w, DW_MIN, DW_MAX);
        de_c     = de_w[DW-1:0];
        err_c    = (e_w != diff_w) || (de_w != dd_w);

        isum_w   = CW'(i_acc) + CW'(prod);
        iclamp_w = clamp_s(isum_w, IM_LO, IM_HI);
        i_next   = iclamp_w[OW-1:0];
        int_c    = (iclamp_w != isum_w);

        ssum_w   = CW'(p_term) + CW'(i_acc) + CW'(d_term);
        oclamp_w = clamp_s(ssum_w, OW_MIN, OW_MAX);
        mv_next  = oclamp_w[OW-1:0];
        out_c    = (oclamp_w != ssum_w);
    end

    // Datapath registers. Each FSM step updates only its own terms; the
    // integrator clear is independent of state and beats the MI update.
    always_ff @(posedge clk) begin
        if (rst) begin
            kp_r       <= '0;
            ki_r       <= '0;
            kd_r       <= '0;
            sv_r       <= '0;
            pv_r       <= '0;
            e_r        <= '0;
            de_r       <= '0;
            e_prev     <= '0;
            p_term     <= '0;
            d_term     <= '0;
            i_acc      <= '0;
            err_flag   <= 1'b0;
            int_flag   <= 1'b0;
            mv         <= '0;
            sat        <= '0;
            sat_sticky <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= (state == SUM);

            if (accept) begin
                kp_r <= kp;
                ki_r <= ki;
                kd_r <= kd;
                sv_r <= sv;
                pv_r <= pv;
            end

            case (state)
                ERR: begin
                    e_r      <= e_c;
                    de_r     <= de_c;
                    err_flag <= err_c;
                end
                MP: begin
                    p_term <= prod;
                end
                MI: begin
                    int_flag <= int_clr ? 1'b0 : int_c;
                end
                MD: begin
                    d_term <= prod;
                    e_prev <= e_r;
                end
                SUM: begin
                    mv                  <= mv_next;
                    sat[SAT_OUT]        <= out_c;
                    sat[SAT_INT]        <= int_flag;
                    sat[SAT_ERR]        <= err_flag;
                    sat_sticky[SAT_OUT] <= sat_sticky[SAT_OUT] | out_c;
                    sat_sticky[SAT_INT] <= sat_sticky[SAT_INT] | int_flag;
                    sat_sticky[SAT_ERR] <= sat_sticky[SAT_ERR] | err_flag;
                end
                default: begin
                end
            endcase

            if (int_clr) begin
                i_acc <= '0;
            end else if (state == MI) begin
                i_acc <= i_next;
            end
        end
    end

endmodule

// File: doc/pid_sat.md
PID_SAT -- requirements
Module: pid_sat

Interface
REQ-001 Parameter DW, default 16: signed width of gains, set value, present value and error.
REQ-002 Parameter OW, default 32: signed width of mv, with OW >= 2*DW.
REQ-003 Parameter I_MAX, default 2^(OW-2)-1: integrator magnitude limit, 0 < I_MAX < 2^(OW-1).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  sample request.
REQ-008 in_ready  out  1  block can accept a sample.
REQ-009 kp, ki, kd  in  DW each  signed gains, captured on accept.
REQ-010 sv, pv  in  DW each  signed set value and present value, captured on accept.
REQ-011 int_clr  in  1  integrator clear pulse.
REQ-012 out_valid  out  1  one-cycle strobe marking a new mv.
REQ-013 mv  out  OW  signed manipulation value, held between strobes.
REQ-014 sat  out  3  {out_clamped, int_clamped, err_clamped}, updated with mv.
REQ-015 sat_sticky  out  3  OR-accumulation of sat; cleared only by rst.

Function
REQ-016 A sample is accepted on a rising edge where in_valid and in_ready are both 1.
- in_ready is 1 only in IDLE.
- in_valid in any other state is ignored.
REQ-017 FSM sequence is IDLE -> ERR -> MP -> MI -> MD -> SUM -> IDLE, one cycle per state.
- Only accept leaves IDLE.
- SUM always returns to IDLE.
REQ-018 ERR computes e = sat_DW(sv - pv) and de = sat_DW(e - e_prev).
- Both are computed at DW+1 bits, then clamped to the signed DW range.
- err_clamped = 1 if either result clamps.
REQ-019 MP: P = kp*e, a full 2*DW-bit signed product.
REQ-020 MI: I_acc = clamp(I_acc + ki*e, -I_MAX, +I_MAX).
- int_clamped = 1 if the clamp engages.
REQ-021 MD: D = kd*de.
- e_prev <= e.
REQ-022 One shared combinational DWxDW signed multiplier is time-multiplexed across MP, MI and MD.
REQ-023 SUM: mv <= clamp_OW(P + I_acc + D).
- The sum is formed at OW+2 bits so it never wraps.
- out_clamped = 1 if the clamp engages.
- Overflow never zeroes mv; it saturates.
REQ-024 Latency: out_valid = 1 in the cycle after the SUM edge, which is 5 cycles after the accept edge.
- in_ready is 1 in that same cycle.
- Maximum throughput is one sample per 6 cycles.
REQ-025 out_valid is high for exactly one cycle per accepted sample.
- mv and sat hold their values until the next strobe.
REQ-026 int_clr = 1 sets I_acc to 0 at the next edge, in any state.
- If int_clr coincides with MI, the clear wins: I_acc = 0 and int_clamped = 0.
REQ-027 sat_sticky |= sat on every SUM edge.
REQ-028 After reset, the first sample uses e_prev = 0.

Reset
REQ-029 rst = 1 at an edge forces the following, regardless of state:
- FSM to IDLE;
- I_acc, e_prev, P, D, mv, sat and sat_sticky to 0;
- out_valid = 0 and in_ready = 1 in the following cycle.
REQ-030 Reset mid-operation aborts the in-flight sample; no out_valid is produced for it.
REQ-031 rst has priority over in_valid and int_clr.

Structure
REQ-032 Package pid_pkg holds:
- the FSM state enum (IDLE, ERR, MP, MI, MD, SUM);
- the sat bit index constants;
- a generic signed clamp function;
- the default parameter values.
REQ-033 The shared multiplier is sub-module pid_mul: parametrised by DW, signed DWxDW -> 2*DW, purely combinational.
REQ-034 The FSM, datapath registers and clamps all reside in pid_sat.

Verification
REQ-035 P-only: DW=16, OW=32, kp=2, ki=0, kd=0, sv=100, pv=40 -> out_valid 5 cycles after accept, mv=120, sat=000.
REQ-036 Integrator: ki=1, kp=kd=0, three samples with sv-pv=10 -> mv=10, 20, 30; a one-cycle int_clr followed by the same sample -> mv=10.
REQ-037 Derivative: kd=3, kp=ki=0, e=5 then e=8 -> mv=15, then mv=9.
REQ-038 Saturation:
- sv=32767, pv=-32768, kp=1 -> e clamps, mv=32767, sat=001.
- I_MAX=1000, ki=100, e=4 repeated -> mv=400, 800, 1000 (sat=010), 1000; sat_sticky=010.
REQ-039 Handshake: in_valid held high continuously -> accepts exactly every 6 cycles; in_ready low in the 5 busy cycles; inputs changing while busy do not affect mv.
REQ-040 Reset mid-operation: rst pulsed in MI -> no out_valid, I_acc=0, mv=0, in_ready=1 on the next cycle; the next sample uses e_prev=0.
